// File: rtl/seg_memory.sv
// MEM pipeline stage: branch resolve, byte/half/word data memory, MEM/WB register.
// Optional debug read port enabled by defining SEG_MEMORY_DEBUG_PORT_EN.
module seg_memory #(
  parameter int LEN          = 32,
  parameter int NB_ADDR      = 5,
  parameter int NB_CTRL_WB   = 2,
  parameter int NB_CTRL_M    = 9,
  parameter int NB_DMEM_ADDR = 10
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_en,
  input  logic [LEN-1:0]          i_PC_branch,
  input  logic [LEN-1:0]          i_ALU_result,
  input  logic                    i_ALU_zero,
  input  logic [LEN-1:0]          i_write_data,
  input  logic [NB_ADDR-1:0]      i_write_register,
  input  logic [NB_CTRL_M-1:0]    i_ctrl_mem_bus,
  input  logic [NB_CTRL_WB-1:0]   i_ctrl_wb_bus,
`ifdef SEG_MEMORY_DEBUG_PORT_EN
  input  logic [NB_DMEM_ADDR-1:0] i_dbg_addr,
  output logic [LEN-1:0]          o_dbg_data,
`endif
  output logic [LEN-1:0]          o_PC_branch,
  output logic                    o_PCSrc,
  output logic [LEN-1:0]          o_read_data,
  output logic [LEN-1:0]          o_ALU_result,
  output logic [NB_ADDR-1:0]      o_write_register,
  output logic [NB_CTRL_WB-1:0]   o_ctrl_wb_bus,
  output logic                    o_misaligned
);

  localparam int DEPTH    = 2 ** NB_DMEM_ADDR;
  localparam int NB_LANES = LEN / 8;

  logic                    branch, branch_ne, mem_read, mem_write, is_unsigned;
  logic [1:0]              size;
  logic                    is_byte, is_half, is_word;
  logic [NB_DMEM_ADDR-1:0] word_idx;
  logic [1:0]              lane;
  logic                    misaligned;
  logic                    store_en;
  logic [LEN-1:0]          rd_word;
  logic [7:0]              rd_byte;
  logic [15:0]             rd_half;
  logic [LEN-1:0]          load_val;
  logic [LEN-1:0]          wr_word;
  logic [NB_LANES-1:0]     wr_be;
  logic                    unused_bits;

  logic [LEN-1:0]          mem_q [DEPTH];

  logic [LEN-1:0]          read_data_q, read_data_d;
  logic [LEN-1:0]          alu_result_q;
  logic [NB_ADDR-1:0]      write_register_q;
  logic [NB_CTRL_WB-1:0]   ctrl_wb_q;
  logic                    misaligned_q, misaligned_d;

  assign branch      = i_ctrl_mem_bus[8];
  assign branch_ne   = i_ctrl_mem_bus[7];
  assign mem_read    = i_ctrl_mem_bus[6];
  assign mem_write   = i_ctrl_mem_bus[5];
  assign size        = i_ctrl_mem_bus[4:3];
  assign is_unsigned = i_ctrl_mem_bus[2];
  assign unused_bits = ^{i_ctrl_mem_bus[1:0], i_ALU_result[LEN-1:NB_DMEM_ADDR+2]};

  assign is_byte = (size == 2'b00);
  assign is_half = (size == 2'b01);
  assign is_word = size[1];

  assign word_idx = i_ALU_result[NB_DMEM_ADDR+1:2];
  assign lane     = i_ALU_result[1:0];

  assign o_PC_branch = i_PC_branch;
  assign o_PCSrc     = i_rst & ((branch & i_ALU_zero) | (branch_ne & ~i_ALU_zero));

  assign misaligned = (mem_read | mem_write) &
                      ((is_half & lane[0]) | (is_word & (lane != 2'b00)));
  assign store_en   = i_rst & i_en & mem_write & ~misaligned;

  // Load path: lane extraction and extension from the pre-write word
  always_comb begin
    rd_word  = mem_q[word_idx];
    rd_byte  = rd_word[{lane, 3'b000} +: 8];
    rd_half  = rd_word[{lane[1], 4'b0000} +: 16];
    load_val = '0;
    if (is_byte)
      load_val = {{(LEN-8){~is_unsigned & rd_byte[7]}}, rd_byte};
    else if (is_half)
      load_val = {{(LEN-16){~is_unsigned & rd_half[15]}}, rd_half};
    else
      load_val = rd_word;
    read_data_d = (mem_read & ~misaligned) ? load_val : '0;
  end

  // Store path: data replicated across lanes, byte enables pick the target lanes
  always_comb begin
    wr_word = i_write_data;
    wr_be   = '1;
    if (is_byte) begin
      wr_word = {NB_LANES{i_write_data[7:0]}};
      wr_be   = {{(NB_LANES-1){1'b0}}, 1'b1} << lane;
    end else if (is_half) begin
      wr_word = {(NB_LANES/2){i_write_data[15:0]}};
      wr_be   = {{(NB_LANES-2){1'b0}}, 2'b11} << {lane[1], 1'b0};
    end
  end

  always_ff @(posedge i_clk) begin
    if (store_en) begin
      for (int unsigned b = 0; b < NB_LANES; b++) begin
        if (wr_be[b])
          mem_q[word_idx][b*8 +: 8] <= wr_word[b*8 +: 8];
      end
    end
  end

  assign misaligned_d = misaligned_q | misaligned;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      read_data_q      <= '0;
      alu_result_q     <= '0;
      write_register_q <= '0;
      ctrl_wb_q        <= '0;
      misaligned_q     <= 1'b0;
    end else if (i_en) begin
      read_data_q      <= read_data_d;
      alu_result_q     <= i_ALU_result;
      write_register_q <= i_write_register;
      ctrl_wb_q        <= i_ctrl_wb_bus;
      misaligned_q     <= misaligned_d;
    end
  end

  assign o_read_data      = read_data_q;
  assign o_ALU_result     = alu_result_q;
  assign o_write_register = write_register_q;
  assign o_ctrl_wb_bus    = ctrl_wb_q;
  assign o_misaligned     = misaligned_q;

`ifdef SEG_MEMORY_DEBUG_PORT_EN
  assign o_dbg_data = mem_q[i_dbg_addr];
`endif

endmodule

// File: tb/tb_seg_memory.sv
// Scoreboard bench for seg_memory: byte-addressed reference memory, expected MEM/WB state queued per edge.
module tb_seg_memory;

  logic        clk;
  logic        rst;
  logic        en;
  logic [31:0] pc_branch;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] write_data;
  logic [4:0]  write_register;
  logic [8:0]  ctrl_mem;
  logic [1:0]  ctrl_wb;
  logic [31:0] pc_branch_o;
  logic        pcsrc;
  logic [31:0] read_data;
  logic [31:0] alu_result_o;
  logic [4:0]  write_register_o;
  logic [1:0]  ctrl_wb_o;
  logic        misaligned_o;

  seg_memory #(
    .LEN(32), .NB_ADDR(5), .NB_CTRL_WB(2), .NB_CTRL_M(9), .NB_DMEM_ADDR(10)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_en(en),
    .i_PC_branch(pc_branch),
    .i_ALU_result(alu_result),
    .i_ALU_zero(alu_zero),
    .i_write_data(write_data),
    .i_write_register(write_register),
    .i_ctrl_mem_bus(ctrl_mem),
    .i_ctrl_wb_bus(ctrl_wb),
    .o_PC_branch(pc_branch_o),
    .o_PCSrc(pcsrc),
    .o_read_data(read_data),
    .o_ALU_result(alu_result_o),
    .o_write_register(write_register_o),
    .o_ctrl_wb_bus(ctrl_wb_o),
    .o_misaligned(misaligned_o)
  );

  typedef struct {
    logic [31:0] rd;
    logic [31:0] alu;
    logic [4:0]  wreg;
    logic [1:0]  wb;
    logic        mis;
  } exp_t;

  exp_t        sbq[$];
  exp_t        st;
  logic [7:0]  bmem [4096];
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b10;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run time expired, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock: drive at negedge, predict next MEM/WB state, compare after the edge.
  task automatic step(input string tag, input bit r, input bit e, input bit mr, input bit mw,
                      input logic [1:0] sz, input bit uns,
                      input logic [31:0] addr, input logic [31:0] wdata);
    logic [11:0] a;
    logic [11:0] base;
    logic [31:0] word;
    logic [15:0] half;
    logic [7:0]  byt;
    logic [31:0] ld;
    bit          mis;
    exp_t        nx;
    exp_t        got;
    @(negedge clk);
    rst            = r;
    en             = e;
    alu_result     = addr;
    write_data     = wdata;
    write_register = 5'($urandom);
    ctrl_wb        = 2'($urandom);
    alu_zero       = 1'($urandom);
    pc_branch      = $urandom;
    ctrl_mem       = {2'b00, mr, mw, sz, uns, 2'($urandom)};

    a    = addr[11:0];
    base = {a[11:2], 2'b00};
    word = {bmem[base+3], bmem[base+2], bmem[base+1], bmem[base]};
    half = {bmem[a+1], bmem[a]};
    byt  = bmem[a];
    mis  = (mr || mw) && ((sz == SZ_H && a[0]) || (sz[1] && a[1:0] != 2'b00));
    if (sz == SZ_B)      ld = uns ? {24'h0, byt} : {{24{byt[7]}}, byt};
    else if (sz == SZ_H) ld = uns ? {16'h0, half} : {{16{half[15]}}, half};
    else                 ld = word;

    nx = st;
    if (!r) begin
      nx = '{rd: 32'h0, alu: 32'h0, wreg: 5'h0, wb: 2'h0, mis: 1'b0};
    end else if (e) begin
      nx.rd   = (mr && !mis) ? ld : 32'h0;
      nx.alu  = addr;
      nx.wreg = write_register;
      nx.wb   = ctrl_wb;
      nx.mis  = st.mis | mis;
      if (mw && !mis) begin
        bmem[a] = wdata[7:0];
        if (sz != SZ_B) bmem[a+1] = wdata[15:8];
        if (sz[1]) begin
          bmem[a+2] = wdata[23:16];
          bmem[a+3] = wdata[31:24];
        end
      end
    end
    st = nx;
    sbq.push_back(nx);

    @(posedge clk);
    #1;
    got = sbq.pop_front();
    check({tag, ".rd"},   read_data,               got.rd);
    check({tag, ".alu"},  alu_result_o,            got.alu);
    check({tag, ".wreg"}, {27'h0, write_register_o}, {27'h0, got.wreg});
    check({tag, ".wb"},   {30'h0, ctrl_wb_o},      {30'h0, got.wb});
    check({tag, ".mis"},  {31'h0, misaligned_o},   {31'h0, got.mis});
  endtask

  task automatic pc_case(input string tag, input bit r, input bit br, input bit bne,
                         input bit z, input bit exp);
    rst      = r;
    ctrl_mem = {br, bne, 7'b0};
    alu_zero = z;
    #1;
    check({tag, ".pcsrc"}, {31'h0, pcsrc}, {31'h0, exp});
  endtask

  initial begin
    st = '{rd: 32'h0, alu: 32'h0, wreg: 5'h0, wb: 2'h0, mis: 1'b0};
    rst = 1'b0; en = 1'b0; pc_branch = '0; alu_result = '0; alu_zero = 1'b0;
    write_data = '0; write_register = '0; ctrl_mem = '0; ctrl_wb = '0;

    step("rst0", 0, 1, 0, 0, SZ_W, 0, 32'h0, 32'h0);
    step("rst1", 0, 0, 0, 0, SZ_W, 0, 32'h4, 32'h0);

    step("sw10",  1, 1, 0, 1, SZ_W, 0, 32'h10, 32'hDEADBEEF);
    step("lw10",  1, 1, 1, 0, SZ_W, 0, 32'h10, 32'h0);
    step("sw20",  1, 1, 0, 1, SZ_W, 0, 32'h20, 32'h11223344);
    step("sb21",  1, 1, 0, 1, SZ_B, 0, 32'h21, 32'hABCDEF80);
    step("lb21",  1, 1, 1, 0, SZ_B, 0, 32'h21, 32'h0);
    step("lbu21", 1, 1, 1, 0, SZ_B, 1, 32'h21, 32'h0);
    step("lw20a", 1, 1, 1, 0, SZ_W, 0, 32'h20, 32'h0);
    step("sh22",  1, 1, 0, 1, SZ_H, 0, 32'h22, 32'hFFFF1234);
    step("lh22",  1, 1, 1, 0, SZ_H, 0, 32'h22, 32'h0);
    step("lw20b", 1, 1, 1, 0, SZ_W, 0, 32'h20, 32'h0);
    step("sh24",  1, 1, 0, 1, SZ_H, 0, 32'h24, 32'h00008001);
    step("lh24",  1, 1, 1, 0, SZ_H, 0, 32'h24, 32'h0);
    step("lhu24", 1, 1, 1, 0, SZ_H, 1, 32'h24, 32'h0);

    // Branch select is combinational; all four checks fit inside one low phase.
    @(negedge clk);
    en = 1'b0;
    pc_branch = 32'h0000_1F00;
    pc_case("beq_z1",  1, 1, 0, 1, 1);
    pc_case("bne_z1",  1, 0, 1, 1, 0);
    pc_case("bne_z0",  1, 0, 1, 0, 1);
    pc_case("rst_low", 0, 1, 0, 1, 0);
    check("pcbranch", pc_branch_o, 32'h0000_1F00);
    rst = 1'b1;

    step("sw30",   1, 1, 0, 1, SZ_W, 0, 32'h30, 32'hA5A5_0001);
    step("en0sw",  1, 0, 0, 1, SZ_W, 0, 32'h30, 32'hB6B6_0002);
    step("lw30a",  1, 1, 1, 0, SZ_W, 0, 32'h30, 32'h0);
    step("rmw30",  1, 1, 1, 1, SZ_W, 0, 32'h30, 32'hD00D_0003);
    step("lw30b",  1, 1, 1, 0, SZ_W, 0, 32'h30, 32'h0);
    step("swwrap", 1, 1, 0, 1, SZ_W, 0, 32'h1034, 32'h5A5A_0FF0);
    step("lwwrap", 1, 1, 1, 0, SZ_W, 0, 32'h34, 32'h0);

    step("sw13",   1, 1, 0, 1, SZ_W, 0, 32'h13, 32'h0000_0000);
    step("lw10b",  1, 1, 1, 0, SZ_W, 0, 32'h10, 32'h0);
    step("lh21",   1, 1, 1, 0, SZ_H, 0, 32'h21, 32'h0);
    step("idle",   1, 1, 0, 0, SZ_W, 0, 32'h8, 32'h0);
    step("rstsw",  0, 1, 0, 1, SZ_W, 0, 32'h30, 32'hEEEE_0004);
    step("lw30c",  1, 1, 1, 0, SZ_W, 0, 32'h30, 32'h0);

    for (int i = 0; i < 16; i++)
      step("init", 1, 1, 0, 1, SZ_W, 0, 32'h40 + 32'(i * 4), $urandom);
    for (int i = 0; i < 40; i++) begin
      logic [1:0]  sz;
      logic [31:0] ad;
      sz = 2'($urandom_range(0, 2));
      ad = 32'h40 + 32'($urandom_range(0, 63));
      if (sz == SZ_H) ad[0] = 1'b0;
      if (sz == SZ_W) ad[1:0] = 2'b00;
      step("rnd", 1, 1, 1'($urandom), 1'($urandom), sz, 1'($urandom), ad, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/seg_memory.md
SEG_MEMORY -- requirements
Module: seg_memory

Interface
REQ-001 Parameter LEN, default 32, datapath width in bits.
REQ-002 Parameter NB_ADDR, default 5, register-file address width.
REQ-003 Parameter NB_CTRL_WB, default 2, write-back control bus width.
REQ-004 Parameter NB_CTRL_M, default 9, memory control bus width.
REQ-005 Parameter NB_DMEM_ADDR, default 10, log2 of data-memory depth in 32-bit words.
REQ-006 i_clk  in  1  clock; all state updates on rising edge.
REQ-007 i_rst  in  1  reset; synchronous, active-low.
REQ-008 i_en  in  1  pipeline enable; low = hold all state, block stores.
REQ-009 i_PC_branch  in  LEN  branch target from execute stage.
REQ-010 i_ALU_result  in  LEN  byte address for loads/stores, or result passed to write-back.
REQ-011 i_ALU_zero  in  1  ALU zero flag.
REQ-012 i_write_data  in  LEN  store data.
REQ-013 i_write_register  in  NB_ADDR  destination register.
REQ-014 i_ctrl_mem_bus  in  NB_CTRL_M  [8] Branch, [7] BranchNE, [6] MemRead, [5] MemWrite, [4:3] Size (00 byte, 01 half, 1x word), [2] Unsigned, [1:0] reserved and ignored.
REQ-015 i_ctrl_wb_bus  in  NB_CTRL_WB  write-back controls, passed through.
REQ-016 o_PC_branch  out  LEN  combinational copy of i_PC_branch.
REQ-017 o_PCSrc  out  1  combinational taken-branch select.
REQ-018 o_read_data  out  LEN  registered, extended load data.
REQ-019 o_ALU_result  out  LEN  registered copy of i_ALU_result.
REQ-020 o_write_register  out  NB_ADDR  registered copy of i_write_register.
REQ-021 o_ctrl_wb_bus  out  NB_CTRL_WB  registered copy of i_ctrl_wb_bus.
REQ-022 o_misaligned  out  1  sticky flag for a misaligned access.

Function
REQ-023 o_PCSrc SHALL be (Branch & i_ALU_zero) | (BranchNE & ~i_ALU_zero); it SHALL be 0 while i_rst is low.
REQ-024 The data memory SHALL hold 2^NB_DMEM_ADDR words, indexed by i_ALU_result[NB_DMEM_ADDR+1:2]; upper address bits are ignored, so accesses wrap.
REQ-025 Store (MemWrite=1, i_en=1), byte: write i_write_data[7:0] to the lane selected by addr[1:0]; other lanes unchanged.
REQ-026 Store, half: write i_write_data[15:0] to the lanes selected by addr[1] (0 = bytes 1:0, 1 = bytes 3:2).
REQ-027 Store, word: write the full word.
REQ-028 Loads SHALL read the addressed word, extract the lane (same lane mapping as stores), zero-extend if Unsigned=1, else sign-extend, and register the result into o_read_data at the same edge; load-to-output latency is 1 cycle.
REQ-029 If MemRead=0, o_read_data SHALL be loaded with 0.
REQ-030 If MemRead and MemWrite are both 1, the access is a store, and o_read_data SHALL capture the pre-write contents (read-before-write).
REQ-031 Misaligned access: half with addr[0]=1, or word with addr[1:0]!=0. The store SHALL be suppressed, the load SHALL return 0, and o_misaligned SHALL set and stay set until reset.
REQ-032 When i_en=0: no memory write, all registered outputs hold, o_misaligned holds; o_PCSrc and o_PC_branch remain combinational.
REQ-033 The MEM/WB outputs (o_read_data, o_ALU_result, o_write_register, o_ctrl_wb_bus) SHALL update every enabled rising edge.

Reset
REQ-034 While i_rst=0, at each rising edge: o_read_data, o_ALU_result, o_write_register, o_ctrl_wb_bus and o_misaligned SHALL clear to 0.
REQ-035 While i_rst=0, all stores are blocked; memory contents are not cleared by reset.
REQ-036 A reset asserted mid-sequence SHALL take priority over i_en and any pending store in the same cycle.

Configuration
REQ-037 Macro SEG_MEMORY_DEBUG_PORT_EN: when defined, add i_dbg_addr (in, NB_DMEM_ADDR) and o_dbg_data (out, LEN), a combinational word read independent of i_en and reset.
REQ-038 When SEG_MEMORY_DEBUG_PORT_EN is undefined, these ports are absent and behaviour is otherwise identical.

Verification
REQ-039 sw 0xDEADBEEF @0x10, then lw @0x10 -> o_read_data=0xDEADBEEF one cycle after the load.
REQ-040 sb 0x80 @0x21, then lb @0x21 -> 0xFFFFFF80; lbu @0x21 -> 0x00000080; word @0x20 has only byte 1 changed.
REQ-041 sh 0x1234 @0x22, then lh @0x22 -> 0x00001234; lw @0x20 upper half = 0x1234.
REQ-042 Branch=1 with zero=1 -> o_PCSrc=1; BranchNE=1 with zero=1 -> 0; BranchNE=1 with zero=0 -> 1; i_rst=0 -> 0.
REQ-043 sw @0x13 -> memory unchanged and o_misaligned=1 stays 1 until i_rst=0.
REQ-044 i_en=0 during a sw @0x30 -> memory unchanged and outputs held; reset asserted during a store -> store blocked and outputs 0 next edge.
